// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder: upstream stage of the HDMI timing driver.
// Buffers RGB565 pixels from the frame-buffer reader in a FIFO and answers the driver's
// data_req with a registered pixel one cycle later. A falling edge of video_vs marks a frame
// boundary: the FIFO is flushed and the reader is told to restart (frame_start). An empty FIFO
// on a request yields FILL_COLOR and sets the sticky underflow flag.
//
// Ports:
//   pixel_clk      in   pixel clock, sole clock
//   sys_rst_n      in   asynchronous active-low reset (deassert synchronously to pixel_clk)
//   video_vs       in   field sync from the driver, low = sync active
//   data_req       in   pixel request from the driver
//   wr_data        in   RGB565 pixel from the frame-buffer reader
//   wr_valid       in   wr_data valid
//   wr_ready       out  FIFO accepts wr_data this cycle
//   frame_start    out  one-cycle pulse, reader restarts at frame address 0
//   video_rgb_565  out  registered pixel to the driver
//   fifo_level     out  current word count (0..2**FIFO_AW)
//   primed         out  level reached PREFILL_LVL this frame
//   underflow      out  sticky, a request hit an empty FIFO this frame
//   frame_done     out  one-cycle pulse after the last pixel of the frame is served
module hdmi_pixel_feeder #(
  parameter int unsigned FIFO_AW     = 9,
  parameter int unsigned H_DISP      = 800,
  parameter int unsigned V_DISP      = 600,
  parameter int unsigned PREFILL_LVL = 256,
  parameter logic [15:0] FILL_COLOR  = 16'h0000
) (
  input  logic               pixel_clk,
  input  logic               sys_rst_n,
  input  logic               video_vs,
  input  logic               data_req,
  input  logic [15:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               frame_start,
  output logic [15:0]        video_rgb_565,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               primed,
  output logic               underflow,
  output logic               frame_done
);

  localparam int unsigned Depth      = 2 ** FIFO_AW;
  localparam int unsigned LvlW       = FIFO_AW + 1;
  localparam logic [LvlW-1:0] FullLvl    = LvlW'(Depth);
  localparam logic [LvlW-1:0] PrefillLvl = LvlW'(PREFILL_LVL);
  localparam logic [19:0] FrameLast  = 20'(H_DISP * V_DISP - 1);

  typedef enum logic [2:0] {StIdle, StFlush, StFill, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic                vs_d_q;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [19:0]         pix_cnt_q, pix_cnt_d;
  logic                primed_q, primed_d;
  logic                underflow_q, underflow_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         rgb_q, rgb_d;
  logic [15:0]         head_q;
  logic [15:0]         mem [Depth];

  logic boundary, full, empty, wr_open, push, serve, pop, miss, last_pix;

  assign boundary = vs_d_q & ~video_vs;
  assign full     = (level_q == FullLvl);
  assign empty    = (level_q == '0);
  // Writes are only taken once a frame has been started and outside the flush cycle.
  assign wr_open  = (state_q == StFill) || (state_q == StStream) || (state_q == StDone);
  assign wr_ready = wr_open & ~full;
  assign push     = wr_valid & wr_ready;
  assign serve    = data_req & ((state_q == StFill) || (state_q == StStream));
  assign pop      = serve & ~empty;
  assign miss     = serve & empty;
  assign last_pix = (pix_cnt_q == FrameLast);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pix_cnt_d    = pix_cnt_q;
    primed_d     = primed_q;
    underflow_d  = underflow_q | miss;
    frame_done_d = serve & last_pix;
    rgb_d        = rgb_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (serve) pix_cnt_d = pix_cnt_q + 20'd1;

    if (pop)                                  rgb_d = head_q;
    else if (miss)                            rgb_d = FILL_COLOR;
    else if (data_req && state_q == StDone)   rgb_d = FILL_COLOR;

    if (wr_open && level_d >= PrefillLvl) primed_d = 1'b1;

    unique case (state_q)
      StIdle:   ;
      StFlush: begin
        state_d     = StFill;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        level_d     = '0;
        pix_cnt_d   = '0;
        primed_d    = 1'b0;
        underflow_d = 1'b0;
      end
      StFill: begin
        if (serve && last_pix)                     state_d = StDone;
        else if (data_req || level_d >= PrefillLvl) state_d = StStream;
      end
      StStream: begin
        if (serve && last_pix) state_d = StDone;
      end
      StDone:   ;
      default:  state_d = StIdle;
    endcase

    // A boundary restarts the frame from any state; unread data is dropped by the flush.
    if (boundary) state_d = StFlush;
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      vs_d_q       <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pix_cnt_q    <= '0;
      primed_q     <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rgb_q        <= FILL_COLOR;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= video_vs;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pix_cnt_q    <= pix_cnt_d;
      primed_q     <= primed_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      rgb_q        <= rgb_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Look-ahead read: head_q always holds the word at the next read pointer, so a pop can load
  // it straight into rgb_q. A push landing on that address (empty FIFO, or one word left and
  // popping) has not reached the RAM yet, so forward it.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      head_q <= '0;
    end else if (push && wr_ptr_q == rd_ptr_d) begin
      head_q <= wr_data;
    end else begin
      head_q <= mem[rd_ptr_d];
    end
  end

  assign frame_start   = (state_q == StFlush);
  assign video_rgb_565 = rgb_q;
  assign fifo_level    = level_q;
  assign primed        = primed_q;
  assign underflow     = underflow_q;
  assign frame_done    = frame_done_q;

endmodule
